// File: rtl/pool_window_gen_pkg.sv
// Shared defaults and sizing helpers for the 2x2 pooling window generator.
package pool_window_gen_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_IMG_WIDTH  = 28;
  localparam int unsigned DEF_IMG_HEIGHT = 28;

  // Counter/address width for a range of n values; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd1) return 32'd1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Simple dual-port line buffer: one synchronous write port, one async read port.
module pool_line_buffer
  import pool_window_gen_pkg::*;
#(
  parameter int unsigned data_width = 2 * DEF_DATA_WIDTH,
  parameter int unsigned depth      = DEF_IMG_WIDTH / 2,
  localparam int unsigned AW        = cnt_width(depth)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [data_width-1:0] rd_data
);

  logic [data_width-1:0] mem [depth];

  // Write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pool_window_gen.sv
// Raster pixel stream to non-overlapping stride-2 2x2 windows for the max-pool unit.
module pool_window_gen
  import pool_window_gen_pkg::*;
#(
  parameter int unsigned data_width = DEF_DATA_WIDTH,
  parameter int unsigned img_width  = DEF_IMG_WIDTH,
  parameter int unsigned img_height = DEF_IMG_HEIGHT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] data_in,
  input  logic                  valid_in,
  output logic [data_width-1:0] out1,
  output logic [data_width-1:0] out2,
  output logic [data_width-1:0] out3,
  output logic [data_width-1:0] out4,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int unsigned CW    = cnt_width(img_width);
  localparam int unsigned RW    = cnt_width(img_height);
  localparam int unsigned DEPTH = img_width / 2;
  localparam int unsigned AW    = cnt_width(DEPTH);

  logic [CW-1:0]           col, col_nxt;
  logic [RW-1:0]           row, row_nxt;
  logic [data_width-1:0]   pair_lo;
  logic [data_width-1:0]   hold;
  logic                    col_last_c, row_last_c;
  logic                    lb_wr_c, win_c;
  logic [AW-1:0]           lb_addr_c;
  logic [2*data_width-1:0] lb_rd_data;

  assign col_last_c = (col == CW'(img_width - 1));
  assign row_last_c = (row == RW'(img_height - 1));
  // Odd columns close a pair; a trailing odd-W column is even-indexed and never closes one.
  assign lb_wr_c    = valid_in & ~row[0] & col[0];
  assign win_c      = valid_in &  row[0] & col[0];
  assign lb_addr_c  = AW'(col >> 1);

  // Raster position advance on each accepted pixel.
  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (valid_in) begin
      if (col_last_c) begin
        col_nxt = '0;
        row_nxt = row_last_c ? '0 : row + RW'(1);
      end else begin
        col_nxt = col + CW'(1);
      end
    end
  end

  pool_line_buffer #(
    .data_width (2 * data_width),
    .depth      (DEPTH)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (lb_wr_c),
    .wr_addr (lb_addr_c),
    .wr_data ({data_in, pair_lo}),
    .rd_addr (lb_addr_c),
    .rd_data (lb_rd_data)
  );

  // Counters, pair/hold staging and registered window outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      pair_lo    <= '0;
      hold       <= '0;
      out1       <= '0;
      out2       <= '0;
      out3       <= '0;
      out4       <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      col        <= col_nxt;
      row        <= row_nxt;
      valid_out  <= win_c;
      frame_done <= valid_in & col_last_c & row_last_c;
      if (valid_in & ~col[0]) begin
        if (row[0]) hold    <= data_in;
        else        pair_lo <= data_in;
      end
      if (win_c) begin
        out1 <= lb_rd_data[data_width-1:0];
        out2 <= lb_rd_data[2*data_width-1:data_width];
        out3 <= hold;
        out4 <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed vector bench for pool_window_gen: a 4x4 and a 5x5 instance.
module tb_pool_window_gen;

  localparam int unsigned DW = 32;

  typedef struct {
    logic          sel;   // 0: 4x4 instance, 1: 5x5 instance
    logic          rst;
    logic          v;
    logic [DW-1:0] d;
    logic          ev;
    logic          efd;
    logic [DW-1:0] e1, e2, e3, e4;
    logic          cmax;
    logic [DW-1:0] emax;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] a_din, b_din;
  logic          a_vin, b_vin;
  logic [DW-1:0] a_o1, a_o2, a_o3, a_o4, b_o1, b_o2, b_o3, b_o4;
  logic          a_vout, a_fd, b_vout, b_fd;

  vec_t          vecs[$];
  logic [DW-1:0] hold [2][4];
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  pool_window_gen #(.data_width(DW), .img_width(4), .img_height(4)) dut_a (
    .clk(clk), .reset(reset), .data_in(a_din), .valid_in(a_vin),
    .out1(a_o1), .out2(a_o2), .out3(a_o3), .out4(a_o4),
    .valid_out(a_vout), .frame_done(a_fd)
  );

  pool_window_gen #(.data_width(DW), .img_width(5), .img_height(5)) dut_b (
    .clk(clk), .reset(reset), .data_in(b_din), .valid_in(b_vin),
    .out1(b_o1), .out2(b_o2), .out3(b_o3), .out4(b_o4),
    .valid_out(b_vout), .frame_done(b_fd)
  );

  task automatic push(input logic sel, input logic rst, input logic v, input logic [DW-1:0] d,
                      input logic ev, input logic efd,
                      input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                      input logic [DW-1:0] e3, input logic [DW-1:0] e4,
                      input logic cmax = 1'b0, input logic [DW-1:0] emax = '0);
    vec_t t;
    t.sel = sel; t.rst = rst; t.v = v; t.d = d; t.ev = ev; t.efd = efd;
    t.e1 = e1; t.e2 = e2; t.e3 = e3; t.e4 = e4; t.cmax = cmax; t.emax = emax;
    vecs.push_back(t);
  endtask

  function automatic logic [DW-1:0] pv(input int base, input bit desc, input int k);
    return desc ? DW'(base - k) : DW'(base + k);
  endfunction

  function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // 4x4 frame: windows close at pixels 5, 7, 13, 15; frame_done with pixel 15.
  task automatic add_frame4(input int base, input bit desc, input bit bubbles, input int n = 16);
    for (int p = 0; p < n; p++) begin
      if (bubbles && ($urandom_range(0, 1) == 1))
        push(1'b0, 1'b0, 1'b0, DW'(32'hBAD0_0000 + p), 1'b0, 1'b0, '0, '0, '0, '0);
      case (p)
        5:  push(1'b0, 1'b0, 1'b1, pv(base, desc, p), 1'b1, 1'b0,
                 pv(base, desc, 0), pv(base, desc, 1), pv(base, desc, 4), pv(base, desc, 5),
                 desc, DW'(15));
        7:  push(1'b0, 1'b0, 1'b1, pv(base, desc, p), 1'b1, 1'b0,
                 pv(base, desc, 2), pv(base, desc, 3), pv(base, desc, 6), pv(base, desc, 7),
                 desc, DW'(13));
        13: push(1'b0, 1'b0, 1'b1, pv(base, desc, p), 1'b1, 1'b0,
                 pv(base, desc, 8), pv(base, desc, 9), pv(base, desc, 12), pv(base, desc, 13),
                 desc, DW'(7));
        15: push(1'b0, 1'b0, 1'b1, pv(base, desc, p), 1'b1, 1'b1,
                 pv(base, desc, 10), pv(base, desc, 11), pv(base, desc, 14), pv(base, desc, 15),
                 desc, DW'(5));
        default: push(1'b0, 1'b0, 1'b1, pv(base, desc, p), 1'b0, 1'b0, '0, '0, '0, '0);
      endcase
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_vin = 1'b0; a_din = '0;
    b_vin = 1'b0; b_din = '0;

    // Reset with valid_in high: reset must dominate.
    push(1'b0, 1'b1, 1'b1, DW'(32'h5555), 1'b0, 1'b0, '0, '0, '0, '0);
    push(1'b0, 1'b1, 1'b1, DW'(32'h6666), 1'b0, 1'b0, '0, '0, '0, '0);
    add_frame4(0, 1'b0, 1'b0);
    add_frame4(0, 1'b0, 1'b1);
    // Back-to-back: frame 0 then frame 100 with no idle cycle.
    add_frame4(0, 1'b0, 1'b0);
    add_frame4(100, 1'b0, 1'b0);
    // Partial frame abandoned by reset after pixel 9, then a clean frame.
    add_frame4(200, 1'b0, 1'b0, 10);
    push(1'b0, 1'b1, 1'b1, DW'(32'h7777), 1'b0, 1'b0, '0, '0, '0, '0);
    add_frame4(0, 1'b0, 1'b0);
    // 5x5: trailing column and row ignored; frame_done alone after pixel 24.
    for (int p = 0; p < 25; p++) begin
      case (p)
        6:  push(1'b1, 1'b0, 1'b1, DW'(p), 1'b1, 1'b0, DW'(0),  DW'(1),  DW'(5),  DW'(6));
        8:  push(1'b1, 1'b0, 1'b1, DW'(p), 1'b1, 1'b0, DW'(2),  DW'(3),  DW'(7),  DW'(8));
        16: push(1'b1, 1'b0, 1'b1, DW'(p), 1'b1, 1'b0, DW'(10), DW'(11), DW'(15), DW'(16));
        18: push(1'b1, 1'b0, 1'b1, DW'(p), 1'b1, 1'b0, DW'(12), DW'(13), DW'(17), DW'(18));
        24: push(1'b1, 1'b0, 1'b1, DW'(p), 1'b0, 1'b1, '0, '0, '0, '0);
        default: push(1'b1, 1'b0, 1'b1, DW'(p), 1'b0, 1'b0, '0, '0, '0, '0);
      endcase
    end
    push(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0);
    // Descending 15..0: window maxima 15, 13, 7, 5.
    add_frame4(15, 1'b1, 1'b0);
    push(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0);

    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 4; k++) hold[s][k] = '0;

    @(negedge clk);
    foreach (vecs[i]) begin
      logic [DW-1:0] g1, g2, g3, g4;
      logic          gv, gfd;
      vec_t          t;
      t = vecs[i];
      reset = t.rst;
      if (t.sel == 1'b0) begin
        a_vin = t.v; a_din = t.d; b_vin = 1'b0;
      end else begin
        b_vin = t.v; b_din = t.d; a_vin = 1'b0;
      end
      @(negedge clk);
      if (t.rst) begin
        for (int s = 0; s < 2; s++)
          for (int k = 0; k < 4; k++) hold[s][k] = '0;
      end else if (t.ev) begin
        hold[t.sel][0] = t.e1; hold[t.sel][1] = t.e2;
        hold[t.sel][2] = t.e3; hold[t.sel][3] = t.e4;
      end
      if (t.sel == 1'b0) begin
        g1 = a_o1; g2 = a_o2; g3 = a_o3; g4 = a_o4; gv = a_vout; gfd = a_fd;
      end else begin
        g1 = b_o1; g2 = b_o2; g3 = b_o3; g4 = b_o4; gv = b_vout; gfd = b_fd;
      end
      chk("valid_out", i, DW'(gv), DW'(t.ev));
      chk("frame_done", i, DW'(gfd), DW'(t.efd));
      chk("out1", i, g1, hold[t.sel][0]);
      chk("out2", i, g2, hold[t.sel][1]);
      chk("out3", i, g3, hold[t.sel][2]);
      chk("out4", i, g4, hold[t.sel][3]);
      if (t.cmax) chk("pool_max", i, max4(g1, g2, g3, g4), t.emax);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
